// File: rtl/aes_rsa_pkg.sv
// Shared types and constants for the AES+RSA result stream packer.
package aes_rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_KEY  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  localparam logic [7:0]  HDR_BYTE   = 8'hA5;
  localparam int unsigned DATA_BYTES = 16;

  // Bytes on the wire for one frame: header + key + AES block + checksum.
  function automatic int unsigned frame_len(input int unsigned w);
    return w / 4 + DATA_BYTES + 2;
  endfunction

endpackage

// File: rtl/aes_rsa_tx_packer.sv
// Serialises {enc_key, d_out} into a header/payload/checksum byte stream
// with valid/ready handshake; one frame per rising edge of done.
module aes_rsa_tx_packer
  import aes_rsa_pkg::*;
#(
  parameter int unsigned W = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [2*W-1:0]   enc_key,
  input  logic [127:0]     d_out,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned KEY_BYTES = W / 4;
  localparam int unsigned CNT_W     = $clog2(KEY_BYTES);
  localparam int unsigned SR_W      = 2 * W + 128;
  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [SR_W-1:0]   r_shift;
  logic [SR_W-1:0]   w_shift_nxt;
  logic [7:0]        r_csum;
  logic [7:0]        w_csum_nxt;
  logic              r_done_q;

  logic [7:0]        r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_overrun;
  logic [7:0]        w_out_data_nxt;
  logic              w_out_valid_nxt;
  logic              w_out_last_nxt;
  logic              w_busy_nxt;
  logic              w_overrun_nxt;

  logic              w_start;
  logic              w_xfer;
  logic [7:0]        w_top;
  logic              w_seg_end;

  assign w_start   = done & ~r_done_q;
  assign w_xfer    = r_out_valid & out_ready;
  assign w_top     = r_shift[SR_W-1 -: 8];
  assign w_seg_end = ((r_state == ST_KEY)  && (r_cnt == KEY_LAST)) ||
                     ((r_state == ST_DATA) && (r_cnt == DATA_LAST));

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

  // Edge detector history; reset high so a done already asserted is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= 1'b1;
    end else begin
      r_done_q <= done;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: every advance out of a busy state is gated by a transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)              w_state_nxt = ST_HDR;
      ST_HDR:  if (w_xfer)               w_state_nxt = ST_KEY;
      ST_KEY:  if (w_xfer && w_seg_end)  w_state_nxt = ST_DATA;
      ST_DATA: if (w_xfer && w_seg_end)  w_state_nxt = ST_CSUM;
      ST_CSUM: if (w_xfer)               w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values; outputs follow next state.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_csum_nxt  = r_csum;

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_shift_nxt = {enc_key, d_out};
          w_csum_nxt  = 8'h00;
          w_cnt_nxt   = '0;
        end
      end
      ST_KEY, ST_DATA: begin
        if (w_xfer) begin
          w_shift_nxt = {r_shift[SR_W-9:0], 8'h00};
          w_csum_nxt  = r_csum ^ w_top;
          w_cnt_nxt   = w_seg_end ? '0 : r_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase

    w_out_valid_nxt = (w_state_nxt != ST_IDLE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_out_last_nxt  = (w_state_nxt == ST_CSUM);
    w_overrun_nxt   = w_start & (r_state != ST_IDLE);

    case (w_state_nxt)
      ST_HDR:           w_out_data_nxt = HDR_BYTE;
      ST_KEY, ST_DATA:  w_out_data_nxt = w_shift_nxt[SR_W-1 -: 8];
      ST_CSUM:          w_out_data_nxt = w_csum_nxt;
      default:          w_out_data_nxt = 8'h00;
    endcase
  end

  // Capture shift register, byte counter and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_csum  <= 8'h00;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_csum  <= w_csum_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

endmodule

// File: tb/tb_aes_rsa_tx_packer.sv
// Bench for aes_rsa_tx_packer: W=64 instance against a frame-queue model
// checked every cycle, plus a W=1024 instance checked on the received stream.
module tb_aes_rsa_tx_packer;

  localparam int unsigned WA = 64;
  localparam int unsigned WB = 1024;
  localparam int unsigned LEN_A = WA / 4 + 18;
  localparam int unsigned LEN_B = WB / 4 + 18;

  logic clk;
  logic rst;

  logic              done_a, valid_a, ready_a, last_a, busy_a, ovr_a;
  logic [2*WA-1:0]   key_a;
  logic [127:0]      din_a;
  logic [7:0]        data_a;

  logic              done_b, valid_b, ready_b, last_b, busy_b, ovr_b;
  logic [2*WB-1:0]   key_b;
  logic [127:0]      din_b;
  logic [7:0]        data_b;

  int n_checks, n_errors;
  int n_busy, n_ovr, n_last, n_last_b, last_b_idx;
  logic [7:0] rx[$];
  logic [7:0] rx_b[$];

  logic [7:0] m_q[$];
  bit         m_done_q;
  bit         m_ovr;

  aes_rsa_tx_packer #(.W(WA)) u_dut_a (
    .clk(clk), .rst(rst), .done(done_a), .enc_key(key_a), .d_out(din_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_last(last_a), .busy(busy_a), .overrun(ovr_a)
  );

  aes_rsa_tx_packer #(.W(WB)) u_dut_b (
    .clk(clk), .rst(rst), .done(done_b), .enc_key(key_b), .d_out(din_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_last(last_b), .busy(busy_b), .overrun(ovr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte idx of a frame built from the rules: header, key MSB first,
  // block MSB first, then XOR of every payload byte.
  function automatic logic [7:0] frame_byte(input logic [2047:0] key, input int nkb,
                                            input logic [127:0] d, input int idx);
    logic [7:0] cs;
    cs = 8'h00;
    if (idx == 0) return 8'hA5;
    if (idx <= nkb) return key[(nkb - idx) * 8 +: 8];
    if (idx <= nkb + 16) return d[(nkb + 16 - idx) * 8 +: 8];
    for (int i = 0; i < nkb; i++) cs = cs ^ key[i * 8 +: 8];
    for (int i = 0; i < 16; i++) cs = cs ^ d[i * 8 +: 8];
    return cs;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of the W=64 instance against the frame queue model.
  task automatic compare_loop();
    bit ev, xfer, start;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        m_done_q = 1'b1;
        m_ovr    = 1'b0;
      end
      ev = (m_q.size() != 0);
      chk("out_valid", 32'(valid_a), 32'(ev));
      chk("busy", 32'(busy_a), 32'(ev));
      chk("overrun", 32'(ovr_a), 32'(m_ovr));
      chk("out_last", 32'(last_a), 32'(ev && m_q.size() == 1));
      if (ev) chk("out_data", 32'(data_a), 32'(m_q[0]));
      else if (rst) chk("out_data_rst", 32'(data_a), 32'h0);
      if (busy_a) n_busy++;
      if (ovr_a) n_ovr++;
      if (!rst) begin
        xfer  = ev && ready_a;
        start = done_a && !m_done_q;
        if (xfer) begin
          rx.push_back(data_a);
          if (last_a) n_last++;
          void'(m_q.pop_front());
        end
        m_ovr = start && ev;
        if (start && !ev)
          for (int i = 0; i < int'(LEN_A); i++)
            m_q.push_back(frame_byte(2048'(key_a), WA / 4, din_a, i));
        m_done_q = done_a;
        if (valid_b && ready_b) begin
          rx_b.push_back(data_b);
          if (last_b) begin
            n_last_b++;
            last_b_idx = rx_b.size();
          end
        end
      end
    end
  endtask

  task automatic start_a(input logic [127:0] k, input logic [127:0] d);
    key_a  = k;
    din_a  = d;
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
  endtask

  task automatic run_until_idle(input bit rnd, input int budget);
    int n;
    n = 0;
    while (busy_a && n < budget) begin
      if (rnd) begin
        ready_a = 1'($urandom_range(0, 1));
        key_a   = {$urandom(), $urandom(), $urandom(), $urandom()};
        din_a   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      n++;
    end
    if (busy_a) chk("frame_timeout", 32'h1, 32'h0);
    ready_a = 1'b1;
  endtask

  task automatic wait_rx(input int cnt);
    int n;
    n = 0;
    while (rx.size() < cnt && n < 300) begin
      tick();
      n++;
    end
    if (rx.size() < cnt) chk("rx_wait_timeout", 32'(rx.size()), 32'(cnt));
  endtask

  logic [127:0] aes_key, aes_dat, rk;
  int b0, o0, l0, n;

  initial begin
    rst = 1'b1;
    done_a = 1'b0; key_a = '0; din_a = '0; ready_a = 1'b1;
    done_b = 1'b0; key_b = '0; din_b = '0; ready_b = 1'b1;
    n_checks = 0; n_errors = 0; n_busy = 0; n_ovr = 0; n_last = 0;
    n_last_b = 0; last_b_idx = 0;
    m_done_q = 1'b1; m_ovr = 1'b0;
    fork
      compare_loop();
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // done already high at reset release must not start a frame
    done_a = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("no_start_after_reset", 32'(busy_a), 32'h0);
    done_a = 1'b0;
    tick();

    // Pin the model against hand-computed values
    aes_key = 128'h00112233445566778899aabbccddeeff;
    aes_dat = 128'h3925841d02dc09fbdc118597196a0b32;
    chk("pin_hdr", 32'(frame_byte(2048'(aes_key), 16, aes_dat, 0)), 32'hA5);
    chk("pin_key_msb", 32'(frame_byte(2048'(aes_key), 16, aes_dat, 1)), 32'h00);
    chk("pin_key_lsb", 32'(frame_byte(2048'(aes_key), 16, aes_dat, 16)), 32'hFF);
    chk("pin_dat_msb", 32'(frame_byte(2048'(aes_key), 16, aes_dat, 17)), 32'h39);
    chk("pin_csum", 32'(frame_byte(2048'(aes_key), 16, aes_dat, 33)), 32'h3C);

    // Basic frame
    rx.delete(); b0 = n_busy; l0 = n_last;
    start_a(128'h0, 128'h01);
    run_until_idle(1'b0, 200);
    chk("basic_len", 32'(rx.size()), 32'(LEN_A));
    if (rx.size() == LEN_A) begin
      chk("basic_hdr", 32'(rx[0]), 32'hA5);
      chk("basic_key0", 32'(rx[1]), 32'h00);
      chk("basic_dat15", 32'(rx[32]), 32'h01);
      chk("basic_csum", 32'(rx[33]), 32'h01);
    end
    chk("basic_busy_cycles", 32'(n_busy - b0), 32'd34);
    chk("basic_last_count", 32'(n_last - l0), 32'd1);
    tick();

    // AES vector
    rx.delete();
    start_a(aes_key, aes_dat);
    chk("aes_valid_after_edge", 32'(valid_a), 32'h1);
    run_until_idle(1'b0, 200);
    chk("aes_len", 32'(rx.size()), 32'(LEN_A));
    if (rx.size() == LEN_A) begin
      chk("aes_key_lsb", 32'(rx[16]), 32'hFF);
      chk("aes_dat_msb", 32'(rx[17]), 32'h39);
      chk("aes_csum", 32'(rx[33]), 32'h3C);
    end
    tick();

    // Backpressure with inputs scrambled after capture
    for (int f = 0; f < 3; f++) begin
      rx.delete();
      start_a({$urandom(), $urandom(), $urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()});
      run_until_idle(1'b1, 400);
      chk("bp_len", 32'(rx.size()), 32'(LEN_A));
      tick();
    end

    // Overrun at byte 10, then done held high after the frame
    rx.delete(); o0 = n_ovr;
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_a(rk, ~rk);
    wait_rx(10);
    done_a = 1'b1;
    run_until_idle(1'b0, 200);
    chk("ovr_pulses", 32'(n_ovr - o0), 32'd1);
    chk("ovr_len", 32'(rx.size()), 32'(LEN_A));
    b0 = n_busy;
    repeat (40) tick();
    chk("held_done_no_frame", 32'(n_busy - b0), 32'd0);
    done_a = 1'b0;
    tick();

    // Start edge coinciding with the checksum transfer
    o0 = n_ovr;
    start_a(rk, rk);
    n = 0;
    while (!last_a && n < 100) begin
      tick();
      n++;
    end
    chk("csum_reached", 32'(last_a), 32'h1);
    done_a = 1'b1;
    repeat (5) tick();
    chk("collision_idle", 32'(busy_a), 32'h0);
    chk("collision_ovr", 32'(n_ovr - o0), 32'd1);
    done_a = 1'b0;
    tick();

    // Reset mid-frame, then a full frame
    l0 = n_last;
    rx.delete();
    start_a(rk, aes_dat);
    wait_rx(20);
    rst = 1'b1;
    #1;
    chk("reset_valid_drop", 32'(valid_a), 32'h0);
    chk("reset_last_low", 32'(last_a), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    rx.delete();
    start_a(aes_key, rk);
    run_until_idle(1'b1, 400);
    chk("post_reset_len", 32'(rx.size()), 32'(LEN_A));
    chk("reset_last_count", 32'(n_last - l0), 32'd1);
    tick();

    // W=1024 smoke
    for (int i = 0; i < int'(2 * WB / 32); i++) key_b[i * 32 +: 32] = 32'h9E3779B9 * 32'(i + 1);
    din_b  = aes_dat;
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    n = 0;
    while (busy_b && n < 3000) begin
      ready_b = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ready_b = 1'b1;
    tick();
    chk("w1024_len", 32'(rx_b.size()), 32'(LEN_B));
    if (rx_b.size() == LEN_B)
      for (int i = 0; i < int'(LEN_B); i++)
        chk("w1024_byte", 32'(rx_b[i]), 32'(frame_byte(key_b, WB / 4, din_b, i)));
    chk("w1024_last_count", 32'(n_last_b), 32'd1);
    chk("w1024_last_pos", 32'(last_b_idx), 32'(LEN_B));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
